// File: rtl/ct_ifu_icache_predecd_refill.sv
// Refill-side predecode generator and write scheduler for icache predecode
// array 0. Each refill beat is predecoded into a 32-bit word (one nibble per
// halfword) and queued. The queue drains into the array whenever fetch leaves
// the array idle. A starvation counter forces a write through after a bounded
// number of blocked cycles.

// Predecode of one halfword. The nibble is {ind, br, jal, is32}.
module ct_ifu_icache_predecd_hw (
    input  logic [15:0] hw_i,
    output logic [3:0]  nib_o
);
    logic is32, jal, br, ind;

    // Classify a 32-bit opcode or an RVC encoding that starts at this halfword.
    always_comb begin
        is32  = (hw_i[1:0] == 2'b11);
        jal   = (is32 & (hw_i[6:0] == 7'b1101111))
              | ((hw_i[1:0] == 2'b01) & (hw_i[15:13] == 3'b101));
        br    = (is32 & (hw_i[6:0] == 7'b1100011))
              | ((hw_i[1:0] == 2'b01) & (hw_i[15:14] == 2'b11));
        ind   = (is32 & (hw_i[6:0] == 7'b1100111))
              | ((hw_i[1:0] == 2'b10) & (hw_i[15:13] == 3'b100)
                 & (hw_i[6:2] == 5'd0) & (hw_i[11:7] != 5'd0));
        nib_o = {ind, br, jal, is32};
    end
endmodule

module ct_ifu_icache_predecd_refill #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4,
    parameter int IDX_W      = 16
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             refill_vld,
    output logic             refill_rdy,
    input  logic [127:0]     refill_data,
    input  logic [IDX_W-1:0] refill_index,
    input  logic             refill_flush,
    input  logic             fetch_req,
    output logic             predecd_cen_b,
    output logic             predecd_wen_b,
    output logic             predecd_clk_en,
    output logic [IDX_W-1:0] predecd_index,
    output logic [31:0]      predecd_din,
    output logic             fetch_stall,
    output logic             predecd_wr_done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [31:0]      pd_word;
    logic [IDX_W-1:0] idx_q [DEPTH];
    logic [31:0]      dat_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             empty, full, force_wr, issue, push;

    // One predecoder per halfword of the beat.
    for (genvar g = 0; g < 8; g++) begin : g_hw
        ct_ifu_icache_predecd_hw u_hw (
            .hw_i  (refill_data[16*g +: 16]),
            .nib_o (pd_word[4*g +: 4])
        );
    end

    // Handshake and arbitration: fetch wins unless the write has starved;
    // a flush cycle neither accepts nor issues.
    always_comb begin
        empty      = (cnt_q == '0);
        full       = (cnt_q == CW'(DEPTH));
        force_wr   = (starve_q == SW'(STARVE_MAX));
        refill_rdy = !full & !refill_flush;
        push       = refill_vld & refill_rdy;
        issue      = !empty & (!fetch_req | force_wr) & !refill_flush;
    end

    // Next-state for pointers, occupancy and starvation counter.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        if (refill_flush) begin
            wptr_d   = '0;
            rptr_d   = '0;
            cnt_d    = '0;
            starve_d = '0;
        end else begin
            if (push)  wptr_d = wptr_q + AW'(1);
            if (issue) rptr_d = rptr_q + AW'(1);
            case ({push, issue})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (issue || empty)           starve_d = '0;
            else if (fetch_req && !force_wr) starve_d = starve_q + SW'(1);
        end
    end

    // Control state register.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Entry storage; written on accept only.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else if (push) begin
            idx_q[wptr_q] <= refill_index;
            dat_q[wptr_q] <= pd_word;
        end
    end

    // Array-side write strobes; index/data track the head and read 0 when empty.
    always_comb begin
        predecd_cen_b   = !issue;
        predecd_wen_b   = !issue;
        predecd_clk_en  = issue;
        predecd_wr_done = issue;
        fetch_stall     = issue & fetch_req;
        predecd_index   = empty ? '0 : idx_q[rptr_q];
        predecd_din     = empty ? '0 : dat_q[rptr_q];
    end
endmodule
